// File: rtl/write_stream.sv
// write_stream: write-side streamer. Buffers a valid/avail input stream in a
// small FIFO and issues sequential write strobes into a MEM instance.
// A job is num_iters * num_writes_per_iter words starting at base_address;
// done pulses in the same cycle as the final write strobe.
// Optional feature macro: WRITE_STREAM_CHECKSUM_EN adds an XOR checksum
// output over every issued word.
module write_stream #(
    parameter int DATA_WIDTH             = 16,
    parameter int LOG_MAX_ITERS          = 4,
    parameter int LOG_MAX_READS_PER_ITER = 8,
    parameter int LOG_MAX_ADDRESS        = 12,
    parameter int LOG_FIFO_DEPTH         = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_writes_per_iter,
    input  logic [LOG_MAX_ADDRESS-1:0]        base_address,
    input  logic                              valid_in,
    input  logic [DATA_WIDTH-1:0]             data_in,
    output logic                              avail_out,
    input  logic                              write_ready,
    output logic                              write,
    output logic [LOG_MAX_ADDRESS-1:0]        addr_write,
    output logic [DATA_WIDTH-1:0]             data_write,
    output logic                              done
`ifdef WRITE_STREAM_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]             checksum
`endif
);

    // total word count fits the product of the two config widths
    localparam int TW    = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;
    localparam int DEPTH = 1 << LOG_FIFO_DEPTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                            state;
    logic [LOG_MAX_ITERS-1:0]          iters_q, iter_cnt;
    logic [LOG_MAX_READS_PER_ITER-1:0] wpi_q, op_cnt;
    logic [TW-1:0]                     total_q, issued_cnt, cfg_total;
    logic [LOG_MAX_ADDRESS-1:0]        next_addr;

    logic [DATA_WIDTH-1:0]             fifo_mem [DEPTH];
    logic [LOG_FIFO_DEPTH-1:0]         rd_ptr, wr_ptr;
    logic [LOG_FIFO_DEPTH:0]           fifo_cnt;
    logic                              fifo_full, fifo_empty;
    logic                              accept, pop, last_accept, last_issue;

    assign cfg_total   = TW'(num_iters) * TW'(num_writes_per_iter);

    // count never exceeds DEPTH, so its MSB alone flags a full FIFO
    assign fifo_full   = fifo_cnt[LOG_FIFO_DEPTH];
    assign fifo_empty  = (fifo_cnt == '0);

    // avail_out depends only on registered state: no same-cycle pop bypass
    assign avail_out   = (state == RUN) && !fifo_full;
    assign accept      = valid_in && avail_out && !configure;
    assign pop         = !fifo_empty && write_ready && !configure;

    assign last_accept = (iter_cnt == iters_q - 1'b1) && (op_cnt == wpi_q - 1'b1);
    assign last_issue  = (issued_cnt == total_q - 1'b1);

    // job FSM: config latch, iteration/op counters on accept, RUN -> DRAIN -> IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            iters_q  <= '0;
            wpi_q    <= '0;
            total_q  <= '0;
            iter_cnt <= '0;
            op_cnt   <= '0;
        end else if (configure) begin
            // also serves as abort when a job is in flight
            iters_q  <= num_iters;
            wpi_q    <= num_writes_per_iter;
            total_q  <= cfg_total;
            iter_cnt <= '0;
            op_cnt   <= '0;
            state    <= (cfg_total != '0) ? RUN : IDLE;
        end else begin
            case (state)
                RUN: begin
                    if (accept) begin
                        if (op_cnt == wpi_q - 1'b1) begin
                            op_cnt   <= '0;
                            iter_cnt <= iter_cnt + 1'b1;
                        end else begin
                            op_cnt   <= op_cnt + 1'b1;
                        end
                        if (last_accept) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && last_issue) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; configure flushes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (configure) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= data_in;
    end

    // registered write issue: pop head, drive strobe/address/data, flag the last word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write      <= 1'b0;
            addr_write <= '0;
            data_write <= '0;
            done       <= 1'b0;
            next_addr  <= '0;
            issued_cnt <= '0;
`ifdef WRITE_STREAM_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else if (configure) begin
            write      <= 1'b0;
            done       <= (cfg_total == '0);
            next_addr  <= base_address;
            issued_cnt <= '0;
`ifdef WRITE_STREAM_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (pop) begin
                write      <= 1'b1;
                data_write <= fifo_mem[rd_ptr];
                addr_write <= next_addr;
                next_addr  <= next_addr + 1'b1;
                issued_cnt <= issued_cnt + 1'b1;
`ifdef WRITE_STREAM_CHECKSUM_EN
                checksum   <= checksum ^ fifo_mem[rd_ptr];
`endif
                if (state == DRAIN && last_issue) done <= 1'b1;
            end else begin
                write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_write_stream.sv
// tb_write_stream: randomized self-checking bench for write_stream.
// Reference model: job k-th accepted word must be written to (base+k) mod 4096,
// in acceptance order, with done flagged on the final write only.
module tb_write_stream;
    localparam int DW = 16, LMI = 4, LMR = 8, LMA = 12, LFD = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           configure = 1'b0, valid_in = 1'b0, write_ready = 1'b0;
    logic [LMI-1:0] num_iters = '0;
    logic [LMR-1:0] num_writes_per_iter = '0;
    logic [LMA-1:0] base_address = '0, addr_write;
    logic [DW-1:0]  data_in = '0, data_write;
    logic           avail_out, write, done;
`ifdef WRITE_STREAM_CHECKSUM_EN
    logic [DW-1:0]  checksum;
    logic [DW-1:0]  cks_at_done;
`endif

    always #5 clk = ~clk;

    write_stream #(.DATA_WIDTH(DW), .LOG_MAX_ITERS(LMI), .LOG_MAX_READS_PER_ITER(LMR),
                   .LOG_MAX_ADDRESS(LMA), .LOG_FIFO_DEPTH(LFD)) dut (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_writes_per_iter(num_writes_per_iter), .base_address(base_address),
        .valid_in(valid_in), .data_in(data_in), .avail_out(avail_out),
        .write_ready(write_ready), .write(write), .addr_write(addr_write),
        .data_write(data_write), .done(done)
`ifdef WRITE_STREAM_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    int checks = 0, passes = 0;
    int done_cnt = 0;
    int cur_base = 0;
    logic [LMA-1:0] got_a[$];
    logic [DW-1:0]  got_d[$];
    logic           got_dn[$];
    logic [DW-1:0]  acc[$];

    // observe MEM-side traffic just after each active edge
    always @(posedge clk) begin
        #1;
        if (write) begin
            got_a.push_back(addr_write);
            got_d.push_back(data_write);
            got_dn.push_back(done);
        end
        if (done) begin
            done_cnt++;
`ifdef WRITE_STREAM_CHECKSUM_EN
            cks_at_done = checksum;
`endif
        end
    end

    function automatic logic [LMA-1:0] model_addr(input int k);
        return 12'((cur_base + k) % 4096);
    endfunction

    // pulse configure for one edge; called and returns at a negedge
    task automatic do_cfg(input int base, input int it, input int wpi);
        got_a.delete(); got_d.delete(); got_dn.delete(); acc.delete();
        done_cnt = 0; cur_base = base;
        base_address = LMA'(base); num_iters = LMI'(it); num_writes_per_iter = LMR'(wpi);
        valid_in = 1'b0; configure = 1'b1;
        @(negedge clk);
        configure = 1'b0;
    endtask

    // offer words until acc holds n; mode 0 random, 1 k+1, 2 one-hot
    task automatic stream(input int n, input int vpct, input int rpct, input int mode,
                          output int cyc);
        cyc = 0;
        while (acc.size() < n && cyc < 2000) begin
            valid_in    = ($urandom_range(99) < vpct);
            write_ready = ($urandom_range(99) < rpct);
            data_in     = (mode == 1) ? DW'(acc.size() + 1) :
                          (mode == 2) ? DW'(1 << acc.size()) : DW'($urandom);
            if (valid_in && avail_out) acc.push_back(data_in);
            @(negedge clk);
            cyc++;
        end
        valid_in = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        write_ready = 1'b1;
        while (done_cnt == 0 && c < budget) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst = 1'b0;
        #4;
        checks++; if (write !== 1'b0) $display("FAIL reset_write: got %b want 0", write); else passes++;
        checks++; if (addr_write !== '0) $display("FAIL reset_addr: got %h want 0", addr_write); else passes++;
        checks++; if (data_write !== '0) $display("FAIL reset_data: got %h want 0", data_write); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
        checks++; if (avail_out !== 1'b0) $display("FAIL reset_avail: got %b want 0", avail_out); else passes++;
`ifdef WRITE_STREAM_CHECKSUM_EN
        checks++; if (checksum !== '0) $display("FAIL reset_checksum: got %h want 0", checksum); else passes++;
`endif
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc;
        do_cfg(32, 2, 4);
        stream(8, 100, 100, 1, cyc);
        checks++; if (cyc !== 8) $display("FAIL basic_b2b: took %0d cycles want 8", cyc); else passes++;
        wait_done(50);
        checks++; if (got_a.size() !== 8) $display("FAIL basic_count: got %0d want 8", got_a.size()); else passes++;
        for (int k = 0; k < got_a.size() && k < 8; k++) begin
            checks++;
            if (got_a[k] !== model_addr(k) || got_d[k] !== DW'(k + 1) || got_dn[k] !== (k == 7))
                $display("FAIL basic_w%0d: got a=%h d=%h done=%b want a=%h d=%h done=%b",
                         k, got_a[k], got_d[k], got_dn[k], model_addr(k), DW'(k + 1), (k == 7));
            else passes++;
        end
        checks++; if (done_cnt !== 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt); else passes++;
        checks++; if (avail_out !== 1'b0) $display("FAIL basic_avail_after: got %b want 0", avail_out); else passes++;
    endtask

    task automatic test_backpressure();
        int cyc;
        do_cfg(100, 1, 8);
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1; write_ready = 1'b0; data_in = DW'($urandom);
            if (avail_out) acc.push_back(data_in);
            @(negedge clk);
        end
        checks++; if (acc.size() !== 4) $display("FAIL bp_accepted: got %0d want 4", acc.size()); else passes++;
        checks++; if (got_a.size() !== 0) $display("FAIL bp_no_write: got %0d writes want 0", got_a.size()); else passes++;
        // pop pending this cycle must not reopen avail_out combinationally
        valid_in = 1'b1; write_ready = 1'b1; data_in = DW'($urandom);
        checks++; if (avail_out !== 1'b0) $display("FAIL bp_full_avail: got %b want 0", avail_out); else passes++;
        @(negedge clk);
        valid_in = 1'b0;
        checks++; if (avail_out !== 1'b1) $display("FAIL bp_reassert: got %b want 1", avail_out); else passes++;
        stream(8, 100, 100, 0, cyc);
        wait_done(50);
        checks++; if (got_a.size() !== 8) $display("FAIL bp_count: got %0d want 8", got_a.size()); else passes++;
        for (int k = 0; k < got_a.size() && k < acc.size(); k++) begin
            checks++;
            if (got_a[k] !== model_addr(k) || got_d[k] !== acc[k] || got_dn[k] !== (k == 7))
                $display("FAIL bp_w%0d: got a=%h d=%h done=%b want a=%h d=%h done=%b",
                         k, got_a[k], got_d[k], got_dn[k], model_addr(k), acc[k], (k == 7));
            else passes++;
        end
    endtask

    task automatic test_wrap();
        int cyc;
        logic [LMA-1:0] want [4] = '{12'd4094, 12'd4095, 12'd0, 12'd1};
        do_cfg(4094, 1, 4);
        stream(4, 100, 100, 0, cyc);
        wait_done(50);
        checks++; if (got_a.size() !== 4) $display("FAIL wrap_count: got %0d want 4", got_a.size()); else passes++;
        for (int k = 0; k < got_a.size() && k < 4; k++) begin
            checks++;
            if (got_a[k] !== want[k] || got_d[k] !== acc[k])
                $display("FAIL wrap_w%0d: got a=%h d=%h want a=%h d=%h", k, got_a[k], got_d[k], want[k], acc[k]);
            else passes++;
        end
    endtask

    task automatic test_random();
        int cyc, it, wpi, n;
        for (int j = 0; j < 5; j++) begin
            it = $urandom_range(3, 1); wpi = $urandom_range(8, 1); n = it * wpi;
            do_cfg($urandom_range(4095), it, wpi);
            stream(n, $urandom_range(100, 30), $urandom_range(100, 20), 0, cyc);
            wait_done(200);
            checks++;
            if (got_a.size() !== n || done_cnt !== 1)
                $display("FAIL rand%0d_count: got %0d writes %0d dones want %0d writes 1 done",
                         j, got_a.size(), done_cnt, n);
            else passes++;
            for (int k = 0; k < got_a.size() && k < acc.size(); k++) begin
                checks++;
                if (got_a[k] !== model_addr(k) || got_d[k] !== acc[k] || got_dn[k] !== (k == n - 1))
                    $display("FAIL rand%0d_w%0d: got a=%h d=%h done=%b want a=%h d=%h done=%b",
                             j, k, got_a[k], got_d[k], got_dn[k], model_addr(k), acc[k], (k == n - 1));
                else passes++;
            end
        end
    endtask

    task automatic test_zero();
        bit avail_seen = 1'b0;
        write_ready = 1'b1;
        do_cfg(7, 0, 5);
        checks++; if (done !== 1'b1) $display("FAIL zero_done_pulse: got %b want 1", done); else passes++;
        @(negedge clk);
        checks++; if (done !== 1'b0) $display("FAIL zero_done_clear: got %b want 0", done); else passes++;
        for (int i = 0; i < 6; i++) begin
            valid_in = 1'b1;
            if (avail_out !== 1'b0) avail_seen = 1'b1;
            @(negedge clk);
        end
        valid_in = 1'b0;
        checks++; if (avail_seen) $display("FAIL zero_avail: got 1 want 0"); else passes++;
        checks++; if (got_a.size() !== 0 || done_cnt !== 1)
            $display("FAIL zero_writes: got %0d writes %0d dones want 0 writes 1 done", got_a.size(), done_cnt);
        else passes++;
    endtask

    task automatic test_abort();
        int cyc;
        do_cfg(200, 1, 8);
        stream(3, 100, 0, 1, cyc);
        write_ready = 1'b1;
        do_cfg(300, 1, 4);
        stream(4, 100, 100, 0, cyc);
        wait_done(50);
        checks++; if (got_a.size() !== 4 || done_cnt !== 1)
            $display("FAIL abort_count: got %0d writes %0d dones want 4 writes 1 done", got_a.size(), done_cnt);
        else passes++;
        for (int k = 0; k < got_a.size() && k < acc.size(); k++) begin
            checks++;
            if (got_a[k] !== model_addr(k) || got_d[k] !== acc[k])
                $display("FAIL abort_w%0d: got a=%h d=%h want a=%h d=%h", k, got_a[k], got_d[k], model_addr(k), acc[k]);
            else passes++;
        end
    endtask

    task automatic test_reset_drain();
        int cyc;
        do_cfg(50, 1, 4);
        stream(4, 100, 0, 1, cyc);
        write_ready = 1'b1;
        @(negedge clk);
        checks++; if (write !== 1'b1) $display("FAIL drain_pre_write: got %b want 1", write); else passes++;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (write !== 1'b0 || addr_write !== '0 || data_write !== '0 || done !== 1'b0 || avail_out !== 1'b0)
            $display("FAIL drain_async_reset: got w=%b a=%h d=%h done=%b avail=%b want all 0",
                     write, addr_write, data_write, done, avail_out);
        else passes++;
        @(negedge clk); rst = 1'b1; write_ready = 1'b0;
        @(negedge clk);
    endtask

`ifdef WRITE_STREAM_CHECKSUM_EN
    task automatic test_checksum();
        int cyc;
        do_cfg(0, 1, 4);
        stream(4, 100, 100, 2, cyc);
        wait_done(50);
        checks++; if (done_cnt !== 1 || cks_at_done !== 16'h000F)
            $display("FAIL checksum: got %h (%0d dones) want 000f (1 done)", cks_at_done, done_cnt);
        else passes++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero();
        test_abort();
        test_random();
        test_reset_drain();
`ifdef WRITE_STREAM_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
